lsu_mem_sequencer: RTL and testbench
====================================

Name: lsu_mem_sequencer

Overview:
Multi-cycle load/store sequencer between the execute stage and the data-memory bus.
- Consumes the one-hot size flags produced by the Funct3 decoder, plus address, store data and destination register.
- Drives a req/ack memory handshake, stalls the pipeline, aligns bytes and sign/zero-extends load data.
- Returns load results for writeback and handles unresponsive memory with a timeout.

Parameters:
TIMEOUT_CYCLES, 255, BUSY cycles without ack before abort; 0 disables timeout.
ADDR_W, 32, byte-address width.

Ports:
iClk  input  1  clock; all state updates on rising edge.
iRstN  input  1  synchronous reset, active-low.
iValid  input  1  execute-stage instruction valid.
iLoad  input  1  instruction is a load.
iStore  input  1  instruction is a store.
iLoadBHW  input  3  one-hot {word, half, byte} signed load size.
iULoadBH  input  2  one-hot {half, byte} unsigned load size.
iStoreBHW  input  3  one-hot {word, half, byte} store size.
iAddr  input  ADDR_W  effective byte address.
iWData  input  32  rs2 store data.
iRd  input  5  load destination register.
oStall  output  1  hold upstream pipeline.
oMemReq  output  1  memory request.
oMemWe  output  1  1 = write.
oMemAddr  output  ADDR_W  word-aligned address ({iAddr[ADDR_W-1:2],2'b00}).
oMemByteEn  output  4  byte lane enables.
oMemWData  output  32  lane-replicated store data.
iMemAck  input  1  memory accepted/completed the request.
iMemRData  input  32  read data, valid with iMemAck.
oWbValid  output  1  one-cycle load writeback strobe.
oWbRd  output  5  writeback register.
oWbData  output  32  extended load data.
oBusErr  output  1  one-cycle timeout pulse.

Behaviour:
- FSM states: IDLE, BUSY, DONE. Reset (iRstN=0 at edge): state IDLE, timeout counter 0, all outputs 0.
- Reset mid-operation aborts the transaction; oMemReq is low from the next cycle.
- IDLE: accepts when iValid & (iLoad|iStore). Captures addr, wdata, size, signedness, rd and we. Next state BUSY.
- iLoad & iStore together: load wins, store ignored.
- Size priority is word > half > byte; no flag set means word.
- oStall = (state==BUSY) | (state==IDLE & accept). oStall is low in DONE so the pipeline advances; DONE always returns to IDLE and never re-accepts.
- BUSY: oMemReq=1 and registered outputs are held stable until iMemAck is sampled high. On ack, capture iMemRData and go to DONE.
- Minimum latency is 2 stall cycles (accept, BUSY-with-ack); writeback occurs in DONE.
- Byte enables:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << {addr[1],1'b0}
  - word: 4'b1111
- oMemWData: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
- Load extract: rdata >> (8*lane offset), where the offset is the same lane offset used for the byte enables. Then sign-extend (iLoadBHW) or zero-extend (iULoadBH) from bit 7/15.
- DONE: a load with rd≠0 asserts oWbValid, oWbRd and oWbData for one cycle. Stores and rd=0 give no strobe.
- Timeout: counter increments each BUSY cycle without ack. When it reaches TIMEOUT_CYCLES, go to DONE with oBusErr=1 and no writeback, and drop oMemReq. Ack on the same cycle as expiry counts as success.
- Without MISALIGN_TRAP_EN, misaligned low bits are silently dropped per the size rules above.

Optional Feature:
MISALIGN_TRAP_EN
- Defined:
  - A misaligned access (half with addr[0]=1; word with addr[1:0]≠0) issues no memory request.
  - IDLE goes directly to DONE with output oMisalign (1 bit, extra port) pulsed for one cycle; no writeback.
  - Latency is 1 stall cycle.
- Undefined: port absent; alignment as in Behaviour.

Decomposition:
- Package lsu_pkg: state enum (IDLE/BUSY/DONE), size enum (SZ_B/SZ_H/SZ_W), MEM_W=32, BE_W=4.
- Sub-module lsu_align (purely combinational): produces byte enables and replicated write data from size/offset, and does load extraction plus extension. The FSM and counter stay in the top module.

Test Plan:
- LW at 0x100, ack in first BUSY cycle, rdata 0xDEADBEEF, rd=5 -> oStall high 2 cycles; oWbValid, rd 5, data 0xDEADBEEF in cycle 3.
- LB at 0x103, rdata 0x80AABBCC -> be 4'b1000, oWbData 0xFFFFFF80. LBU same access -> 0x00000080.
- SH at 0x202, wdata 0x00001234 -> oMemAddr 0x200, be 4'b1100, oMemWData 0x12341234, oMemWe=1; no oWbValid.
- LW with ack after 3 wait cycles -> oMemReq and address stable 4 BUSY cycles, oStall high 5 cycles.
- TIMEOUT_CYCLES=4, never ack -> oBusErr pulse after 4 BUSY cycles, no writeback, next access accepted normally.
- iRstN low during BUSY -> next cycle oMemReq=0, oStall=0, state IDLE. With MISALIGN_TRAP_EN, LW at 0x101 -> no oMemReq, oMisalign pulse.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and helpers for the load/store sequencer.
//   state_t   : sequencer FSM states (IDLE/BUSY/DONE)
//   size_t    : access size (byte/half/word)
//   lane_off  : byte-lane offset used for both byte enables and load extraction
//   misaligned: true when an access does not sit on its natural boundary
package lsu_pkg;
    localparam int MEM_W = 32;
    localparam int BE_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    function automatic logic [1:0] lane_off(input size_t sz, input logic [1:0] lo);
        case (sz)
            SZ_B:    return lo;
            SZ_H:    return {lo[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic misaligned(input size_t sz, input logic [1:0] lo);
        return ((sz == SZ_H) && lo[0]) || ((sz == SZ_W) && (lo != 2'b00));
    endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: purely combinational lane steering for the sequencer.
// Ports:
//   size      in  access size
//   off       in  byte-lane offset (already reduced to the size's alignment)
//   is_signed in  sign-extend (1) or zero-extend (0) sub-word loads
//   wdata     in  raw store data
//   rdata     in  raw read data from memory
//   byte_en   out byte lane enables
//   wdata_rep out store data replicated across lanes
//   ld_data   out extracted and extended load result
module lsu_align
    import lsu_pkg::*;
(
    input  size_t             size,
    input  logic [1:0]        off,
    input  logic              is_signed,
    input  logic [MEM_W-1:0]  wdata,
    input  logic [MEM_W-1:0]  rdata,
    output logic [BE_W-1:0]   byte_en,
    output logic [MEM_W-1:0]  wdata_rep,
    output logic [MEM_W-1:0]  ld_data
);
    logic [MEM_W-1:0] shifted;

    always_comb begin
        shifted   = rdata >> {off, 3'b000};
        byte_en   = 4'b1111;
        wdata_rep = wdata;
        ld_data   = shifted;
        case (size)
            SZ_B: begin
                byte_en   = 4'b0001 << off;
                wdata_rep = {4{wdata[7:0]}};
                ld_data   = {{24{is_signed & shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                byte_en   = 4'b0011 << off;
                wdata_rep = {2{wdata[15:0]}};
                ld_data   = {{16{is_signed & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/lsu_mem_sequencer.sv
// lsu_mem_sequencer: multi-cycle load/store sequencer between execute and
// the data-memory bus. Accepts one access, holds the pipeline while a
// req/ack transaction runs, then returns load results for writeback.
//
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses
// skip the bus and pulse oMisalign instead (adds the oMisalign port).
//
// Ports: iClk/iRstN (sync active-low reset); execute side iValid, iLoad,
// iStore, iLoadBHW, iULoadBH, iStoreBHW, iAddr, iWData, iRd, oStall;
// memory side oMemReq, oMemWe, oMemAddr, oMemByteEn, oMemWData, iMemAck,
// iMemRData; writeback oWbValid, oWbRd, oWbData; oBusErr timeout pulse.
//
// state | meaning
// IDLE  | waiting for a load/store; accepting stalls this cycle
// BUSY  | request on the bus, waiting for ack or timeout
// DONE  | result cycle: writeback / error / misalign pulse, pipeline released
module lsu_mem_sequencer
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iValid,
    input  logic              iLoad,
    input  logic              iStore,
    input  logic [2:0]        iLoadBHW,
    input  logic [1:0]        iULoadBH,
    input  logic [2:0]        iStoreBHW,
    input  logic [ADDR_W-1:0] iAddr,
    input  logic [31:0]       iWData,
    input  logic [4:0]        iRd,
    output logic              oStall,
    output logic              oMemReq,
    output logic              oMemWe,
    output logic [ADDR_W-1:0] oMemAddr,
    output logic [3:0]        oMemByteEn,
    output logic [31:0]       oMemWData,
    input  logic              iMemAck,
    input  logic [31:0]       iMemRData,
    output logic              oWbValid,
    output logic [4:0]        oWbRd,
    output logic [31:0]       oWbData,
`ifdef MISALIGN_TRAP_EN
    output logic              oMisalign,
`endif
    output logic              oBusErr
);
    state_t            state_q, state_d;
    logic [31:0]       cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q, rdata_q;
    size_t             size_q, size_in;
    logic              sgn_q, sgn_in;
    logic [4:0]        rd_q;
    logic              we_q, ld_q, err_q, mis_q;
    logic              accept, expire, trap_in, busy, done, wb_fire;
    logic [3:0]        be;
    logic [31:0]       wrep, ld_data;

    assign accept = (state_q == IDLE) && iValid && (iLoad || iStore);
    // A zero TIMEOUT_CYCLES never expires; ack in the expiry cycle wins (checked first in BUSY).
    assign expire = (TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));

    // Load flags take over whenever iLoad is set, so a load+store decodes as a load.
    always_comb begin
        size_in = SZ_W;
        sgn_in  = 1'b0;
        if (iLoad) begin
            if (iLoadBHW[2]) begin
                size_in = SZ_W;
            end else if (iLoadBHW[1] || iULoadBH[1]) begin
                size_in = SZ_H;
                sgn_in  = iLoadBHW[1];
            end else if (iLoadBHW[0] || iULoadBH[0]) begin
                size_in = SZ_B;
                sgn_in  = iLoadBHW[0];
            end
        end else begin
            if (iStoreBHW[2])      size_in = SZ_W;
            else if (iStoreBHW[1]) size_in = SZ_H;
            else if (iStoreBHW[0]) size_in = SZ_B;
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign trap_in = misaligned(size_in, iAddr[1:0]);
`else
    assign trap_in = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = trap_in ? DONE : BUSY;
            BUSY:    if (iMemAck || expire) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            size_q  <= SZ_W;
            sgn_q   <= 1'b0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            ld_q    <= 1'b0;
            err_q   <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (accept) begin
                    addr_q  <= iAddr;
                    wdata_q <= iWData;
                    size_q  <= size_in;
                    sgn_q   <= sgn_in;
                    rd_q    <= iRd;
                    ld_q    <= iLoad;
                    we_q    <= iStore && !iLoad;
                    cnt_q   <= '0;
                    err_q   <= 1'b0;
                    mis_q   <= trap_in;
                end
                BUSY: begin
                    if (iMemAck)     rdata_q <= iMemRData;
                    else if (expire) err_q   <= 1'b1;
                    else             cnt_q   <= cnt_q + 32'd1;
                end
                default: ;
            endcase
        end
    end

    lsu_align u_align (
        .size      (size_q),
        .off       (lane_off(size_q, addr_q[1:0])),
        .is_signed (sgn_q),
        .wdata     (wdata_q),
        .rdata     (rdata_q),
        .byte_en   (be),
        .wdata_rep (wrep),
        .ld_data   (ld_data)
    );

    assign busy    = (state_q == BUSY);
    assign done    = (state_q == DONE);
    assign wb_fire = done && ld_q && (rd_q != 5'd0) && !err_q && !mis_q;

    // Bus outputs are zeroed outside BUSY so nothing leaks while idle.
    assign oStall     = busy || accept;
    assign oMemReq    = busy;
    assign oMemWe     = busy && we_q;
    assign oMemAddr   = busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign oMemByteEn = busy ? be : 4'b0000;
    assign oMemWData  = busy ? wrep : 32'd0;
    assign oWbValid   = wb_fire;
    assign oWbRd      = wb_fire ? rd_q : 5'd0;
    assign oWbData    = wb_fire ? ld_data : 32'd0;
    assign oBusErr    = done && err_q;
`ifdef MISALIGN_TRAP_EN
    assign oMisalign  = done && mis_q;
`endif
endmodule

// File: tb/tb_lsu_mem_sequencer.sv
module tb_lsu_mem_sequencer;
    localparam int TO = 4;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
    logic oMisalign;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        iClk = 1'b0;
    logic        iRstN, iValid, iLoad, iStore, iMemAck;
    logic [2:0]  iLoadBHW, iStoreBHW;
    logic [1:0]  iULoadBH;
    logic [31:0] iAddr, iWData, iMemRData;
    logic [4:0]  iRd;
    logic        oStall, oMemReq, oMemWe, oWbValid, oBusErr;
    logic [31:0] oMemAddr, oMemWData, oWbData;
    logic [3:0]  oMemByteEn;
    logic [4:0]  oWbRd;

    int n_checks = 0;
    int n_err    = 0;

    always #5 iClk = ~iClk;

    lsu_mem_sequencer #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
        .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .iLoad(iLoad), .iStore(iStore),
        .iLoadBHW(iLoadBHW), .iULoadBH(iULoadBH), .iStoreBHW(iStoreBHW),
        .iAddr(iAddr), .iWData(iWData), .iRd(iRd), .oStall(oStall),
        .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr),
        .oMemByteEn(oMemByteEn), .oMemWData(oMemWData), .iMemAck(iMemAck),
        .iMemRData(iMemRData), .oWbValid(oWbValid), .oWbRd(oWbRd), .oWbData(oWbData),
`ifdef MISALIGN_TRAP_EN
        .oMisalign(oMisalign),
`endif
        .oBusErr(oBusErr)
    );

    typedef struct {
        logic        ld, st;
        logic [2:0]  lbhw;
        logic [1:0]  ulbh;
        logic [2:0]  sbhw;
        logic [31:0] addr, wdata;
        logic [4:0]  rd;
        int          delay;
        logic [31:0] rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
        logic        exp_wb;
        logic [31:0] exp_wbdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: size chosen word > half > byte, lane picked from the address,
    // value extended arithmetically.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int sz = 2;
        bit uns = 1'b0;
        int off;
        logic [3:0]  b;
        logic [31:0] sh, val;
        if (v.ld) begin
            if (v.lbhw[2]) sz = 2;
            else if (v.lbhw[1] || v.ulbh[1]) begin sz = 1; uns = !v.lbhw[1]; end
            else if (v.lbhw[0] || v.ulbh[0]) begin sz = 0; uns = !v.lbhw[0]; end
        end else begin
            if (v.sbhw[2]) sz = 2;
            else if (v.sbhw[1]) sz = 1;
            else if (v.sbhw[0]) sz = 0;
        end
        off = (sz == 0) ? int'(v.addr % 4) : (sz == 1) ? ((v.addr % 4 >= 2) ? 2 : 0) : 0;
        b = (sz == 2) ? 4'd15 : (sz == 1) ? 4'd3 : 4'd1;
        r.exp_be = b << off;
        r.exp_wd = (sz == 0) ? 32'(v.wdata[7:0]) * 32'h01010101 :
                   (sz == 1) ? 32'(v.wdata[15:0]) * 32'h00010001 : v.wdata;
        sh = v.rdata >> (8 * off);
        val = sh;
        if (sz == 0) begin
            val = sh % 256;
            if (!uns && val >= 128) val = val - 256;
        end else if (sz == 1) begin
            val = sh % 65536;
            if (!uns && val >= 32768) val = val - 65536;
        end
        r.exp_wbdata = val;
        r.exp_wb = v.ld && (v.rd != 0);
        return r;
    endfunction

    task automatic run_txn(input int id, input vec_t v);
        bit mis, err, wb, we;
        int busy_n, stalls;
        string t;
        t = $sformatf("t%0d", id);
        mis = TRAP && (((v.exp_be == 4'b1111) && (v.addr[1:0] != 2'b00)) ||
                       (((v.exp_be == 4'b0011) || (v.exp_be == 4'b1100)) && v.addr[0]));
        err = !mis && (v.delay >= TO);
        wb  = v.exp_wb && !err && !mis;
        we  = v.st && !v.ld;
        busy_n = mis ? 0 : ((v.delay < TO) ? v.delay + 1 : TO);
        stalls = 0;
        @(posedge iClk); #1;
        iValid = 1'b1; iLoad = v.ld; iStore = v.st; iLoadBHW = v.lbhw; iULoadBH = v.ulbh;
        iStoreBHW = v.sbhw; iAddr = v.addr; iWData = v.wdata; iRd = v.rd;
        #3;
        if (oStall) stalls++;
        chk({t, " idle_req"}, 32'(oMemReq), 32'd0);
        @(posedge iClk); #1;
        iValid = 1'b0; iLoad = 1'b0; iStore = 1'b0;
        iWData = $urandom; iAddr = $urandom;
        for (int i = 0; i < busy_n; i++) begin
            iMemAck = (i == v.delay);
            iMemRData = iMemAck ? v.rdata : $urandom;
            #3;
            if (oStall) stalls++;
            chk({t, " req"}, 32'(oMemReq), 32'd1);
            chk({t, " addr"}, oMemAddr, {v.addr[31:2], 2'b00});
            chk({t, " be"}, 32'(oMemByteEn), 32'(v.exp_be));
            chk({t, " we"}, 32'(oMemWe), 32'(we));
            if (we) chk({t, " wdata"}, oMemWData, v.exp_wd);
            @(posedge iClk); #1;
            iMemAck = 1'b0;
        end
        // New request offered in DONE must not be taken.
        iValid = 1'b1; iLoad = 1'b1;
        #3;
        if (oStall) stalls++;
        chk({t, " stall_cycles"}, 32'(stalls), 32'(busy_n + 1));
        chk({t, " done_req"}, 32'(oMemReq), 32'd0);
        chk({t, " wb_valid"}, 32'(oWbValid), 32'(wb));
        chk({t, " wb_rd"}, 32'(oWbRd), wb ? 32'(v.rd) : 32'd0);
        chk({t, " wb_data"}, oWbData, wb ? v.exp_wbdata : 32'd0);
        chk({t, " bus_err"}, 32'(oBusErr), 32'(err));
`ifdef MISALIGN_TRAP_EN
        chk({t, " misalign"}, 32'(oMisalign), 32'(mis));
`endif
        @(posedge iClk); #1;
        iValid = 1'b0; iLoad = 1'b0;
        #3;
        chk({t, " back_idle"}, 32'({oStall, oMemReq}), 32'd0);
    endtask

    function automatic vec_t mk(input logic ld, st, input logic [2:0] lbhw, input logic [1:0] ulbh,
                                input logic [2:0] sbhw, input logic [31:0] addr, wdata,
                                input logic [4:0] rd, input int delay, input logic [31:0] rdata,
                                input logic [3:0] be, input logic [31:0] wd, input logic wb,
                                input logic [31:0] wbd);
        vec_t v;
        v.ld = ld; v.st = st; v.lbhw = lbhw; v.ulbh = ulbh; v.sbhw = sbhw;
        v.addr = addr; v.wdata = wdata; v.rd = rd; v.delay = delay; v.rdata = rdata;
        v.exp_be = be; v.exp_wd = wd; v.exp_wb = wb; v.exp_wbdata = wbd;
        return v;
    endfunction

    vec_t tbl[14];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = mk(1,0,3'b100,2'b00,3'b000,32'h100,32'h0,   5,0, 32'hDEADBEEF,4'b1111,32'h0,1,32'hDEADBEEF);
        tbl[1]  = mk(1,0,3'b001,2'b00,3'b000,32'h103,32'h0,   7,0, 32'h80AABBCC,4'b1000,32'h0,1,32'hFFFFFF80);
        tbl[2]  = mk(1,0,3'b000,2'b01,3'b000,32'h103,32'h0,   7,1, 32'h80AABBCC,4'b1000,32'h0,1,32'h00000080);
        tbl[3]  = mk(0,1,3'b000,2'b00,3'b010,32'h202,32'h1234,4,0, 32'h0,       4'b1100,32'h12341234,0,32'h0);
        tbl[4]  = mk(1,0,3'b100,2'b00,3'b000,32'h40, 32'h0,   9,3, 32'h11223344,4'b1111,32'h0,1,32'h11223344);
        tbl[5]  = mk(1,0,3'b100,2'b00,3'b000,32'h44, 32'h0,   3,10,32'h55555555,4'b1111,32'h0,1,32'h55555555);
        tbl[6]  = mk(1,0,3'b010,2'b00,3'b000,32'h102,32'h0,   2,0, 32'h80017FFF,4'b1100,32'h0,1,32'hFFFF8001);
        tbl[7]  = mk(1,0,3'b000,2'b10,3'b000,32'h102,32'h0,   2,2, 32'h80017FFF,4'b1100,32'h0,1,32'h00008001);
        tbl[8]  = mk(0,1,3'b000,2'b00,3'b001,32'h005,32'hABCD12EF,1,1,32'h0,    4'b0010,32'hEFEFEFEF,0,32'h0);
        tbl[9]  = mk(1,0,3'b100,2'b00,3'b000,32'h20, 32'h0,   0,0, 32'h12345678,4'b1111,32'h0,0,32'h0);
        tbl[10] = mk(1,1,3'b001,2'b00,3'b100,32'h001,32'hFFFFFFFF,6,0,32'h00005A00,4'b0010,32'h0,1,32'h0000005A);
        tbl[11] = mk(1,0,3'b100,2'b00,3'b000,32'h101,32'h0,   8,0, 32'h01020304,4'b1111,32'h0,1,32'h01020304);
        tbl[12] = mk(1,0,3'b000,2'b00,3'b000,32'h8,  32'h0,  10,0, 32'hA5A5A5A5,4'b1111,32'h0,1,32'hA5A5A5A5);
        tbl[13] = mk(0,1,3'b000,2'b00,3'b100,32'h10, 32'hCAFEF00D,0,2,32'h0,    4'b1111,32'hCAFEF00D,0,32'h0);

        iRstN = 1'b0; iValid = 1'b0; iLoad = 1'b0; iStore = 1'b0; iMemAck = 1'b0;
        iLoadBHW = '0; iULoadBH = '0; iStoreBHW = '0; iAddr = '0; iWData = '0;
        iRd = '0; iMemRData = '0;
        repeat (2) @(posedge iClk);
        #1 iRstN = 1'b1;
        #3;
        chk("reset_outs", 32'({oStall, oMemReq, oMemWe, oWbValid, oBusErr}), 32'd0);
        chk("reset_bus", oMemAddr | oMemWData | oWbData | 32'(oMemByteEn) | 32'(oWbRd), 32'd0);

        for (int i = 0; i < 14; i++) run_txn(i, tbl[i]);

        // iValid without load or store is not an access.
        @(posedge iClk); #1;
        iValid = 1'b1;
        #3 chk("nop_stall", 32'(oStall), 32'd0);
        @(posedge iClk); #1 iValid = 1'b0;
        #3 chk("nop_req", 32'(oMemReq), 32'd0);

        // Reset while BUSY aborts the transaction.
        @(posedge iClk); #1;
        iValid = 1'b1; iLoad = 1'b1; iLoadBHW = 3'b100; iAddr = 32'h300; iRd = 5'd1;
        @(posedge iClk); #1;
        iValid = 1'b0; iLoad = 1'b0;
        #3 chk("rst_busy_req", 32'(oMemReq), 32'd1);
        @(posedge iClk); #1 iRstN = 1'b0;
        @(posedge iClk); #1 iRstN = 1'b1;
        #3 chk("rst_abort", 32'({oMemReq, oStall, oWbValid, oBusErr}), 32'd0);
        @(posedge iClk); #4 chk("rst_stays_idle", 32'({oMemReq, oStall}), 32'd0);
        run_txn(100, tbl[0]);

        for (int n = 0; n < 150; n++) begin
            vec_t v;
            v.ld = 1'($urandom); v.st = 1'($urandom);
            if (!v.ld && !v.st) v.ld = 1'b1;
            v.lbhw = 3'($urandom); v.ulbh = 2'($urandom); v.sbhw = 3'($urandom);
            v.addr = $urandom; v.wdata = $urandom; v.rd = 5'($urandom);
            v.delay = $urandom_range(0, 5); v.rdata = $urandom;
            run_txn(200 + n, model(v));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
